vga_sync_ctrl: RTL
==================

Name: vga_sync_ctrl

Overview:
- Timing master for the VGA path: generates the pixelX/pixelY scan coordinates that the background and object drawers consume.
- Accepts the drawers' 8-bit RRRGGGBB pixel after a fixed pipeline latency.
- Drives the VGA connector: HS, VS, blank and 8-bit-per-channel RGB, with sync and blank delay-matched to the drawer pipeline.
- Default timing is 640x480@60 at a 25 MHz pixel rate; the pixel rate is selected via pixelEn.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIXEL_LATENCY, 1, pixel-enabled cycles from coordinate out to matching RGB_in (legal 1..4)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pixelEn  in  1  pixel-rate enable; counters and pipeline advance only when high
- RGB_in  in  8  drawer pixel {R[2:0],G[2:0],B[1:0]}
- pixelX  out  11  current horizontal count
- pixelY  out  11  current vertical count
- startOfFrame  out  1  one-pixel pulse at the start of each frame
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_BLANK_N  out  1  low outside the active area
- VGA_R / VGA_G / VGA_B  out  8 each  expanded colour

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Counters are 11-bit unsigned; pixelX/pixelY are the registered counters directly.
- Reset (async assert, sync release):
  - hcount = vcount = 0.
  - All delay stages cleared to inactive values (HS=1, VS=1, active=0).
  - Outputs: VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_R/G/B=0, startOfFrame=0.
- Stall: when pixelEn=0, every register holds, including counters, delay line and outputs.
- Counting, on a pixelEn cycle:
  - If hcount==H_TOTAL-1: hcount←0, and vcount←(vcount==V_TOTAL-1 ? 0 : vcount+1).
  - Otherwise hcount←hcount+1.
  - Counters never exceed TOTAL-1.
- Decode, combinational from the counters:
  - act = hcount<H_ACTIVE && vcount<V_ACTIVE.
  - hs_n low iff H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_n low iff V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC (490..491).
- Alignment:
  - act, hs_n and vs_n pass through a PIXEL_LATENCY-stage shift register clocked on pixelEn.
  - Output registers load on pixelEn from the last stage and from RGB_in.
  - The coordinate shown at enabled cycle t appears on the VGA outputs at enabled cycle t+PIXEL_LATENCY+1.
- Colour expansion, applied only when delayed act=1; otherwise R/G/B are forced to 0 (RGB_in ignored):
  - VGA_R={R,R,R[2:1]}
  - VGA_G={G,G,G[2:1]}
  - VGA_B={B,B,B,B}
- VGA_BLANK_N equals delayed act.
- startOfFrame:
  - Registered; set for exactly one enabled cycle when the counters wrap from (H_TOTAL-1,V_TOTAL-1) to (0,0).
  - Coincides with pixelX=0, pixelY=0. Not asserted for the first frame after reset.
- Reset mid-frame: counters and pipeline clear immediately; scanning restarts at (0,0) on the first enabled cycle after release; no partial sync pulse is emitted.

Test Plan:
- Release reset with pixelEn=1 constantly, run 420000 cycles → pixelX sequence 0..799 repeats; pixelY 0..524; startOfFrame high exactly once, at cycle 420000 with pixelX=pixelY=0.
- Line timing check on vcount=10 → VGA_HS low for exactly 96 enabled cycles, beginning PIXEL_LATENCY+1 cycles after pixelX=656; VGA_BLANK_N high for 640 cycles per visible line.
- Frame timing → VGA_VS low for 2×800 cycles, starting with the line where pixelY=490 (delayed by PIXEL_LATENCY+1); VGA_BLANK_N low for all of lines 480..524.
- PIXEL_LATENCY=2, drawer model returns RGB_in=8'hE3 two cycles after (pixelX,pixelY)=(5,5) → VGA_R=8'hFF, VGA_G=8'h00, VGA_B=8'hFF three cycles after (5,5). RGB_in=8'hFF during pixelX=700 → output 0.
- pixelEn toggling 1,0,1,0 (50 MHz clk, 25 MHz pixels) → counters advance every other clk; all outputs hold on pixelEn=0 cycles; the frame takes 840000 clks.
- Assert reset at pixelX=300, pixelY=200 for 3 cycles → all outputs at reset values within the same cycle; after release, pixelX/pixelY restart at 0/0; no startOfFrame pulse until the next wrap.

Source files
------------

// File: rtl/vga_sync_ctrl.sv
// VGA timing master: scan counters, sync/blank decode, and a delay line that
// lines sync and blank up with the drawer pixel arriving PIXEL_LATENCY enables later.
module vga_sync_ctrl #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter int PIXEL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixelEn,
  input  logic [7:0]  RGB_in,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B
);

  localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hcount, vcount;
  logic [PIXEL_LATENCY-1:0] act_d, hs_d, vs_d;
  logic act, hs_n, vs_n;
  logic [2:0] r_in, g_in;
  logic [1:0] b_in;

  assign pixelX = hcount;
  assign pixelY = vcount;

  assign act  = (hcount < H_ACT) && (vcount < V_ACT);
  assign hs_n = !((hcount >= HS_START) && (hcount < HS_END));
  assign vs_n = !((vcount >= VS_START) && (vcount < VS_END));

  assign r_in = RGB_in[7:5];
  assign g_in = RGB_in[4:2];
  assign b_in = RGB_in[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount       <= '0;
      vcount       <= '0;
      act_d        <= '0;
      hs_d         <= '1;
      vs_d         <= '1;
      startOfFrame <= 1'b0;
      VGA_HS       <= 1'b1;
      VGA_VS       <= 1'b1;
      VGA_BLANK_N  <= 1'b0;
      VGA_R        <= '0;
      VGA_G        <= '0;
      VGA_B        <= '0;
    end else if (pixelEn) begin
      if (hcount == H_LAST) begin
        hcount <= '0;
        vcount <= (vcount == V_LAST) ? 11'd0 : vcount + 11'd1;
      end else begin
        hcount <= hcount + 11'd1;
      end
      startOfFrame <= (hcount == H_LAST) && (vcount == V_LAST);

      act_d[0] <= act;
      hs_d[0]  <= hs_n;
      vs_d[0]  <= vs_n;
      for (int i = 1; i < PIXEL_LATENCY; i++) begin
        act_d[i] <= act_d[i-1];
        hs_d[i]  <= hs_d[i-1];
        vs_d[i]  <= vs_d[i-1];
      end

      // Last delay stage now matches the pixel the drawer is presenting.
      VGA_HS      <= hs_d[PIXEL_LATENCY-1];
      VGA_VS      <= vs_d[PIXEL_LATENCY-1];
      VGA_BLANK_N <= act_d[PIXEL_LATENCY-1];
      if (act_d[PIXEL_LATENCY-1]) begin
        VGA_R <= {r_in, r_in, r_in[2:1]};
        VGA_G <= {g_in, g_in, g_in[2:1]};
        VGA_B <= {b_in, b_in, b_in, b_in};
      end else begin
        VGA_R <= '0;
        VGA_G <= '0;
        VGA_B <= '0;
      end
    end
  end

endmodule
